// File: rtl/alu_src2_pkg.sv
// Shared select codes and FSM state type for the ALU operand-2 stage.
// Imported by alu_src2_seq and its helpers.
package alu_src2_pkg;

  localparam logic [2:0] S2_RM            = 3'd0;
  localparam logic [2:0] S2_IMM32         = 3'd1;
  localparam logic [2:0] S2_NOT_RM        = 3'd2;
  localparam logic [2:0] S2_NOT_IMM32     = 3'd3;
  localparam logic [2:0] S2_BIT_COUNT     = 3'd4;
  localparam logic [2:0] S2_NOT_BIT_COUNT = 3'd5;
  localparam logic [2:0] S2_LIST          = 3'd6;
  localparam logic [2:0] S2_RSVD          = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

endpackage

// File: rtl/reglist_popcount.sv
// Register-list helper: population count and index of the lowest set bit.
// Ports: bits (list in), count (IDX_W+1 bits), lowest (0 when list empty).
module reglist_popcount #(
  parameter int REGLIST_W = 16
) (
  input  logic [REGLIST_W-1:0]         bits,
  output logic [$clog2(REGLIST_W):0]   count,
  output logic [$clog2(REGLIST_W)-1:0] lowest
);

  localparam int IDX_W = $clog2(REGLIST_W);
  localparam int CNT_W = IDX_W + 1;

  // Scan high to low so the last hit is the lowest set bit.
  always_comb begin
    count  = '0;
    lowest = '0;
    for (int i = REGLIST_W - 1; i >= 0; i--) begin
      if (bits[i]) begin
        count  = count + CNT_W'(1);
        lowest = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_src2_seq.sv
// Registered ALU operand-2 stage: operand select/invert, list byte count,
// and LDM/STM register-list walker emitting one offset beat per register.
// Ports: clk, reset (sync, high); in_valid/in_ready, src_sel, rm, imm32,
// reg_list; out_valid/out_ready, alu_src2, list_reg, list_last; busy.
module alu_src2_seq
  import alu_src2_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REGLIST_W = 16,
  parameter int STEP_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   src_sel,
  input  logic [DATA_W-1:0]            rm,
  input  logic [DATA_W-1:0]            imm32,
  input  logic [REGLIST_W-1:0]         reg_list,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            alu_src2,
  output logic [$clog2(REGLIST_W)-1:0] list_reg,
  output logic                         list_last,
  output logic                         busy
);

  localparam int IDX_W = $clog2(REGLIST_W);
  localparam int CNT_W = IDX_W + 1;

  state_t               state;
  logic [REGLIST_W-1:0] rem;
  logic [REGLIST_W-1:0] rem_next;
  logic [REGLIST_W-1:0] pc_in;
  logic [CNT_W-1:0]     k;
  logic [CNT_W-1:0]     k_next;
  logic [CNT_W-1:0]     pc_cnt;
  logic [IDX_W-1:0]     pc_low;
  logic [DATA_W-1:0]    cnt_bytes;
  logic [DATA_W-1:0]    next_off;
  logic [DATA_W-1:0]    single_val;
  logic                 in_fire;
  logic                 start_seq;
  logic                 pc_one;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign busy     = (state == SEQ);

  // Drop the bit of the beat being presented now.
  assign rem_next = rem & (rem - REGLIST_W'(1));

  // One counter serves both the incoming list (IDLE) and
  // the list that remains after the current beat (SEQ).
  assign pc_in = (state == SEQ) ? rem_next : reg_list;

  reglist_popcount #(
    .REGLIST_W (REGLIST_W)
  ) u_pop (
    .bits   (pc_in),
    .count  (pc_cnt),
    .lowest (pc_low)
  );

  assign pc_one    = (pc_cnt == CNT_W'(1));
  assign k_next    = k + CNT_W'(1);
  assign cnt_bytes = DATA_W'(pc_cnt) << STEP_LOG2;
  assign next_off  = DATA_W'(k_next) << STEP_LOG2;
  assign start_seq = (src_sel == S2_LIST) && (|reg_list);

  always_comb begin
    single_val = '0;
    unique case (src_sel)
      S2_RM:            single_val = rm;
      S2_IMM32:         single_val = imm32;
      S2_NOT_RM:        single_val = ~rm;
      S2_NOT_IMM32:     single_val = ~imm32;
      S2_BIT_COUNT:     single_val = cnt_bytes;
      S2_NOT_BIT_COUNT: single_val = ~cnt_bytes;
      S2_LIST:          single_val = '0;
      S2_RSVD:          single_val = '0;
      default:          single_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      alu_src2  <= '0;
      list_reg  <= '0;
      list_last <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            out_valid <= 1'b1;
            if (start_seq) begin
              state     <= SEQ;
              rem       <= reg_list;
              k         <= '0;
              alu_src2  <= '0;
              list_reg  <= pc_low;
              list_last <= pc_one;
            end else begin
              alu_src2  <= single_val;
              list_reg  <= '0;
              list_last <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        SEQ: begin
          // A beat is always presented in SEQ, so out_ready
          // alone means the current beat is consumed.
          if (out_ready) begin
            if (rem_next == '0) begin
              state     <= IDLE;
              rem       <= '0;
              k         <= '0;
              out_valid <= 1'b0;
            end else begin
              rem       <= rem_next;
              k         <= k_next;
              alu_src2  <= next_off;
              list_reg  <= pc_low;
              list_last <= pc_one;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_src2_seq.sv
// Testbench for alu_src2_seq: directed cases with literal expectations,
// then randomized traffic checked against a queue-based beat model.
module tb_alu_src2_seq;

  localparam int DATA_W    = 32;
  localparam int REGLIST_W = 16;
  localparam int STEP_LOG2 = 2;
  localparam int IDX_W     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        src_sel;
  logic [31:0]       rm;
  logic [31:0]       imm32;
  logic [15:0]       reg_list;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       alu_src2;
  logic [IDX_W-1:0]  list_reg;
  logic              list_last;
  logic              busy;

  always #5 clk = ~clk;

  alu_src2_seq #(
    .DATA_W    (DATA_W),
    .REGLIST_W (REGLIST_W),
    .STEP_LOG2 (STEP_LOG2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src_sel   (src_sel),
    .rm        (rm),
    .imm32     (imm32),
    .reg_list  (reg_list),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_src2  (alu_src2),
    .list_reg  (list_reg),
    .list_last (list_last),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0]      val;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             seq;
  } beat_t;

  beat_t       q[$];
  logic [31:0] log_val[$];
  logic [3:0]  log_idx[$];
  logic        logging = 1'b0;
  logic        acc;
  int          passed = 0;
  int          total  = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_val;
  logic [3:0]  prev_idx;
  logic        prev_last;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [31:0] single_val(input logic [2:0] sel,
      input logic [31:0] r, input logic [31:0] im, input logic [15:0] l);
    logic [31:0] bytes;
    bytes = 32'($countones(l)) * 32'd4;
    case (sel)
      3'd0: return r;
      3'd1: return im;
      3'd2: return ~r;
      3'd3: return ~im;
      3'd4: return bytes;
      3'd5: return ~bytes;
      default: return 32'd0;
    endcase
  endfunction

  task automatic push_op(input logic [2:0] sel, input logic [31:0] r,
                         input logic [31:0] im, input logic [15:0] l);
    beat_t b;
    int    n;
    if (sel == 3'd6 && l != 16'd0) begin
      n = 0;
      for (int i = 0; i < 16; i++) begin
        if (l[i]) begin
          b.val  = 32'(n * 4);
          b.idx  = 4'(i);
          b.last = 1'b0;
          b.seq  = 1'b1;
          q.push_back(b);
          n++;
        end
      end
      q[q.size()-1].last = 1'b1;
    end else begin
      b.val  = single_val(sel, r, im, l);
      b.idx  = '0;
      b.last = 1'b1;
      b.seq  = 1'b0;
      q.push_back(b);
    end
  endtask

  // Called at a negedge with inputs already driven: checks outputs,
  // advances the model across the coming posedge, then returns at
  // the following negedge.
  task automatic tick();
    logic ev, eb, eir;
    #1;
    ev  = (q.size() != 0);
    eb  = ev && q[0].seq;
    eir = !eb && (!ev || out_ready);
    check("out_valid", 32'(out_valid), 32'(ev));
    check("busy", 32'(busy), 32'(eb));
    check("in_ready", 32'(in_ready), 32'(eir));
    if (ev) begin
      check("alu_src2", alu_src2, q[0].val);
      check("list_reg", 32'(list_reg), 32'(q[0].idx));
      check("list_last", 32'(list_last), 32'(q[0].last));
    end
    if (prev_stall) begin
      check("stall_val", alu_src2, prev_val);
      check("stall_idx", 32'(list_reg), 32'(prev_idx));
      check("stall_last", 32'(list_last), 32'(prev_last));
    end
    prev_stall = out_valid && !out_ready && !reset;
    prev_val   = alu_src2;
    prev_idx   = list_reg;
    prev_last  = list_last;
    if (logging && out_valid && out_ready && !reset) begin
      log_val.push_back(alu_src2);
      log_idx.push_back(list_reg);
    end
    acc = in_valid && eir && !reset;
    if (reset) begin
      q.delete();
    end else begin
      if (ev && out_ready) void'(q.pop_front());
      if (acc) push_op(src_sel, rm, imm32, reg_list);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] sel, input logic [31:0] r,
                       input logic [31:0] im, input logic [15:0] l);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    src_sel  = sel;
    rm       = r;
    imm32    = im;
    reg_list = l;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      done = acc;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL accept_timeout: got not-accepted want accepted");
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    tick();
    total++;
    if (q.size() == 0 && !out_valid) passed++;
    else $display("FAIL drain_timeout: got %0d pending want 0", q.size());
  endtask

  initial begin
    logic [31:0] exp_v[9];
    logic [3:0]  exp_i[9];

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    src_sel   = '0;
    rm        = '0;
    imm32     = '0;
    reg_list  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_src2", alu_src2, 32'd0);
    check("rst_list_reg", 32'(list_reg), 32'd0);
    check("rst_list_last", 32'(list_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    check("pin_bitcount", single_val(3'd4, 0, 0, 16'h00F1), 32'h14);
    check("pin_notbitcount", single_val(3'd5, 0, 0, 16'h00F1), 32'hFFFF_FFEB);
    check("pin_notrm", single_val(3'd2, 32'h1234_5678, 0, 0), 32'hEDCB_A987);

    logging = 1'b1;
    issue(3'd0, 32'h1234_5678, 32'h0, 16'h0);
    issue(3'd2, 32'h1234_5678, 32'h0, 16'h0);
    issue(3'd4, 32'h0, 32'h0, 16'h00F1);
    issue(3'd5, 32'h0, 32'h0, 16'h00F1);
    issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF);
    issue(3'd6, 32'h0, 32'h0, 16'h8005);
    issue(3'd6, 32'h0, 32'h0, 16'h0000);
    drain();
    logging = 1'b0;

    exp_v = '{32'h1234_5678, 32'hEDCB_A987, 32'h14, 32'hFFFF_FFEB,
              32'h0, 32'h0, 32'h4, 32'h8, 32'h0};
    exp_i = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd15, 4'd0};
    check("dir_count", 32'(log_val.size()), 32'd9);
    for (int i = 0; i < 9 && i < log_val.size(); i++) begin
      check($sformatf("dir_val%0d", i), log_val[i], exp_v[i]);
      check($sformatf("dir_idx%0d", i), 32'(log_idx[i]), 32'(exp_i[i]));
    end

    issue(3'd6, 32'h0, 32'h0, 16'h00FF);
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 3 == 0);
      tick();
    end
    drain();

    issue(3'd6, 32'h0, 32'h0, 16'hFFFF);
    out_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    log_val.delete();
    logging = 1'b1;
    issue(3'd0, 32'hCAFE_F00D, 32'h0, 16'h0);
    drain();
    logging = 1'b0;
    check("post_rst_count", 32'(log_val.size()), 32'd1);
    if (log_val.size() != 0)
      check("post_rst_val", log_val[0], 32'hCAFE_F00D);

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      src_sel   = 3'($urandom_range(0, 7));
      rm        = $urandom;
      imm32     = $urandom;
      case ($urandom_range(0, 3))
        0: reg_list = 16'h0;
        1: reg_list = 16'(1 << $urandom_range(0, 15));
        default: reg_list = 16'($urandom);
      endcase
      out_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
